// File: rtl/arbitro_rr_pkg.sv
// Shared constants and FSM encoding for the round-robin FIFO arbiter.
package arbitro_rr_pkg;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned N_VC     = 4;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned DEST_MSB = 9;
    localparam int unsigned DEST_W   = DEST_MSB - DEST_LSB + 1;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/arbitro_rr_rr_grant.sv
// Round-robin priority encoder: first eligible source at or after ptr wins.
module rr_grant #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] pos;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < int'(N); k++) begin
            pos = ptr + PTR_W'(k);
            if (!found && eligible[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving words from N_VC show-ahead FIFOs to N_VC
// destination FIFOs, with per-destination push counters readable when idle.
module arbitro_rr #(
    parameter int unsigned DATA_W = arbitro_rr_pkg::DATA_W,
    parameter int unsigned N_VC   = arbitro_rr_pkg::N_VC
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_VC-1:0]                  empty,
    input  logic [DATA_W-1:0]                data_in0,
    input  logic [DATA_W-1:0]                data_in1,
    input  logic [DATA_W-1:0]                data_in2,
    input  logic [DATA_W-1:0]                data_in3,
    input  logic [N_VC-1:0]                  alm_full,
    output logic [N_VC-1:0]                  pop,
    output logic [N_VC-1:0]                  push,
    output logic [DATA_W-1:0]                data_out,
    output logic                             idle,
    input  logic                             req,
    input  logic [arbitro_rr_pkg::IDX_W-1:0] idx,
    output logic [arbitro_rr_pkg::CNT_W-1:0] cnt_data,
    output logic                             cnt_valid
);

    import arbitro_rr_pkg::*;

    localparam int unsigned PTR_W = $clog2(N_VC);

    logic [DATA_W-1:0] head [N_VC];
    logic [N_VC-1:0]   eligible;
    logic [N_VC-1:0]   grant;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [DATA_W-1:0] pop_word;
    logic [CNT_W-1:0]  cnt [N_VC];
    state_e            state;
    state_e            state_nxt;

    assign head[0] = data_in0;
    assign head[1] = data_in1;
    assign head[2] = data_in2;
    assign head[3] = data_in3;

    // A source may go only if its head's destination has room right now.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(N_VC); i++) begin
            eligible[i] = !empty[i] && !alm_full[head[i][DEST_MSB:DEST_LSB]];
        end
    end

    rr_grant #(
        .N     (N_VC),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    always_comb begin
        pop_word = '0;
        ptr_nxt  = ptr;
        for (int i = 0; i < int'(N_VC); i++) begin
            if (pop[i]) begin
                pop_word = head[i];
                ptr_nxt  = PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are held off during INIT so the first pop follows a settled cycle.
    always_comb begin
        state_nxt = state;
        pop       = '0;
        case (state)
            S_INIT: begin
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                pop = grant;
                if (|eligible) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                pop = grant;
                if (!(|eligible) && !(|push)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    assign idle = (state == S_IDLE) && (&empty);

    // One-cycle pipeline from pop to push; words are pushed regardless of alm_full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            push     <= '0;
            data_out <= '0;
        end else begin
            push     <= '0;
            data_out <= '0;
            if (|pop) begin
                ptr                                   <= ptr_nxt;
                push[pop_word[DEST_MSB:DEST_LSB]]     <= 1'b1;
                data_out                              <= pop_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < int'(N_VC); d++) begin
                cnt[d] <= '0;
            end
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
        end else begin
            for (int d = 0; d < int'(N_VC); d++) begin
                if (push[d]) begin
                    cnt[d] <= cnt[d] + 1'b1;
                end
            end
            cnt_valid <= req && idle;
            cnt_data  <= (req && idle) ? cnt[idx] : '0;
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr with hand-computed expectations.
module tb_arbitro_rr;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] empty;
    logic [9:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0] alm_full;
    logic [3:0] pop;
    logic [3:0] push;
    logic [9:0] data_out;
    logic       idle;
    logic       req;
    logic [1:0] idx;
    logic [4:0] cnt_data;
    logic       cnt_valid;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arbitro_rr dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .alm_full  (alm_full),
        .pop       (pop),
        .push      (push),
        .data_out  (data_out),
        .idle      (idle),
        .req       (req),
        .idx       (idx),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset    = 1'b1;
        empty    = 4'hF;
        alm_full = 4'h0;
        req      = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (idle !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("wait_idle", 32'(idle), 32'h1);
    endtask

    task automatic read_cnt(input logic [1:0] d, input logic [4:0] exp);
        idx = d;
        req = 1'b1;
        step();
        req = 1'b0;
        #1;
        check("cnt_valid", 32'(cnt_valid), 32'h1);
        check("cnt_data", 32'(cnt_data), 32'(exp));
        step();
        #1;
        check("cnt_valid_drop", 32'(cnt_valid), 32'h0);
        check("cnt_data_drop", 32'(cnt_data), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          exp_src [5];
        logic [9:0]  words   [4];

        exp_src = '{0, 1, 2, 3, 0};
        words   = '{10'h011, 10'h022, 10'h033, 10'h044};

        reset    = 1'b1;
        empty    = 4'hF;
        alm_full = 4'h0;
        data_in0 = '0;
        data_in1 = '0;
        data_in2 = '0;
        data_in3 = '0;
        req      = 1'b0;
        idx      = '0;

        // reset holds every output low even with work offered
        #2;
        empty = 4'h0;
        req   = 1'b1;
        #1;
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_idle", 32'(idle), 32'h0);
        step();
        check("rst_cnt_valid", 32'(cnt_valid), 32'h0);
        check("rst_cnt_data", 32'(cnt_data), 32'h0);
        empty = 4'hF;
        req   = 1'b0;
        reset = 1'b0;
        step();
        #1;
        check("idle_after_init", 32'(idle), 32'h1);

        // single word 0x1A5 from FIFO0 to dest 1
        data_in0 = 10'h1A5;
        empty    = 4'b1110;
        #1;
        check("single_pop", 32'(pop), 32'h1);
        check("single_idle_low", 32'(idle), 32'h0);
        step();
        empty = 4'hF;
        #1;
        check("single_push", 32'(push), 32'h2);
        check("single_data", 32'(data_out), 32'h1A5);
        check("single_no_pop", 32'(pop), 32'h0);
        step();
        #1;
        check("single_push_drop", 32'(push), 32'h0);
        wait_idle();
        read_cnt(2'd1, 5'd1);

        // four busy sources to dest 0: grants rotate 0,1,2,3,0
        do_reset();
        data_in0 = words[0];
        data_in1 = words[1];
        data_in2 = words[2];
        data_in3 = words[3];
        empty    = 4'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_pop", 32'(pop), 32'(1 << exp_src[k]));
            if (k > 0) begin
                check("rr_push", 32'(push), 32'h1);
                check("rr_data", 32'(data_out), 32'(words[exp_src[k-1]]));
            end
            step();
        end
        empty = 4'hF;
        #1;
        check("rr_last_push", 32'(push), 32'h1);
        check("rr_last_data", 32'(data_out), 32'(words[0]));
        check("rr_last_no_pop", 32'(pop), 32'h0);
        wait_idle();
        read_cnt(2'd0, 5'd5);

        // dest 2 almost full: FIFO1 waits, FIFO3 goes
        data_in1 = 10'h2AB;
        data_in3 = 10'h0CD;
        alm_full = 4'b0100;
        empty    = 4'b0101;
        #1;
        check("blk_pop3", 32'(pop), 32'h8);
        step();
        empty = 4'b1101;
        #1;
        check("blk_pop_none", 32'(pop), 32'h0);
        check("blk_push0", 32'(push), 32'h1);
        check("blk_data", 32'(data_out), 32'h0CD);
        step();
        #1;
        check("blk_still_none", 32'(pop), 32'h0);
        check("blk_push_drop", 32'(push), 32'h0);
        step();
        alm_full = 4'h0;
        #1;
        check("unblk_pop1", 32'(pop), 32'h2);
        step();
        empty = 4'hF;
        #1;
        check("unblk_push2", 32'(push), 32'h4);
        check("unblk_data", 32'(data_out), 32'h2AB);
        wait_idle();

        // alm_full rises after the pop: in-flight word still lands
        data_in0 = 10'h3C3;
        empty    = 4'b1110;
        #1;
        check("late_af_pop", 32'(pop), 32'h1);
        step();
        alm_full = 4'b1000;
        data_in0 = 10'h33C;
        #1;
        check("late_af_push", 32'(push), 32'h8);
        check("late_af_data", 32'(data_out), 32'h3C3);
        check("late_af_no_pop", 32'(pop), 32'h0);
        step();
        #1;
        check("late_af_held", 32'(pop), 32'h0);
        check("late_af_push_drop", 32'(push), 32'h0);
        empty    = 4'hF;
        alm_full = 4'h0;
        wait_idle();

        // 33 pushes to dest 3 wrap the counter to 1
        do_reset();
        data_in0 = 10'h300;
        empty    = 4'b1110;
        req      = 1'b1;
        idx      = 2'd3;
        for (int k = 0; k < 33; k++) begin
            #1;
            check("wrap_pop", 32'(pop), 32'h1);
            step();
        end
        empty = 4'hF;
        #1;
        check("busy_cnt_valid", 32'(cnt_valid), 32'h0);
        check("wrap_last_push", 32'(push), 32'h8);
        req = 1'b0;
        wait_idle();
        read_cnt(2'd3, 5'd1);

        // reset between pop and push discards the word
        data_in2 = 10'h155;
        empty    = 4'b1011;
        #1;
        check("mid_pop2", 32'(pop), 32'h4);
        step();
        empty = 4'hF;
        #1;
        check("mid_push_pre", 32'(push), 32'h2);
        reset = 1'b1;
        #1;
        check("mid_push_async", 32'(push), 32'h0);
        check("mid_data_out", 32'(data_out), 32'h0);
        check("mid_pop", 32'(pop), 32'h0);
        check("mid_idle", 32'(idle), 32'h0);
        step();
        step();
        reset = 1'b0;
        step();
        data_in0 = words[0];
        data_in1 = words[1];
        data_in2 = words[2];
        data_in3 = words[3];
        empty    = 4'h0;
        #1;
        check("post_rst_pop0", 32'(pop), 32'h1);
        step();
        empty = 4'hF;
        #1;
        check("post_rst_push", 32'(push), 32'h1);
        check("post_rst_data", 32'(data_out), 32'(words[0]));
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 SHALL have parameter DATA_W, default 10: width of one FIFO word.
REQ-002 SHALL have parameter N_VC, default 4: number of upstream FIFOs and of downstream destinations.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port empty, input, N_VC bits: empty flag of each upstream FIFO.
REQ-006 SHALL have port data_in0..data_in3, input, DATA_W bits each: show-ahead head word of each upstream FIFO; bits [9:8] give the destination index.
REQ-007 SHALL have port alm_full, input, N_VC bits: almost-full flag of each downstream FIFO.
REQ-008 SHALL have port pop, output, N_VC bits: one-hot read strobe to the upstream FIFOs.
REQ-009 SHALL have port push, output, N_VC bits: one-hot write strobe to the downstream FIFOs.
REQ-010 SHALL have port data_out, output, DATA_W bits: word written to the downstream FIFOs.
REQ-011 SHALL have port idle, output, 1 bit: high when no word is in flight and all upstream FIFOs are empty.
REQ-012 SHALL have port req, input, 1 bit: counter read request.
REQ-013 SHALL have port idx, input, 2 bits: destination counter selected for reading.
REQ-014 SHALL have port cnt_data, output, 5 bits: value of the selected destination counter.
REQ-015 SHALL have port cnt_valid, output, 1 bit: qualifies cnt_data.

Function
REQ-016 SHALL treat source i as eligible when empty[i]=0 and alm_full[data_in_i[9:8]]=0.
REQ-017 SHALL assert at most one pop bit per cycle, combinationally, for the eligible source chosen by round-robin.
REQ-018 SHALL search round-robin starting at the source after the last granted one; after reset the search starts at source 0.
REQ-019 SHALL register the popped word and its destination on the pop edge.
REQ-020 SHALL in the next cycle drive data_out with the registered word and push[dest]=1, giving exactly 1 cycle of latency from pop to push.
REQ-021 SHALL sample alm_full only in the pop cycle; a word already in flight SHALL be pushed even if alm_full rises afterwards (the FIFO threshold provides the margin).
REQ-022 SHALL support back-to-back pops, giving one push per cycle at sustained throughput.
REQ-023 SHALL implement FSM states INIT, IDLE and ACTIVE.
- INIT -> IDLE on the first cycle after reset.
- IDLE -> ACTIVE when any source is eligible.
- ACTIVE -> IDLE when no source is eligible and no word is in flight.
REQ-024 SHALL drive idle=1 only in IDLE with empty all ones.
REQ-025 SHALL keep one 5-bit counter per destination, incremented on each push to that destination and wrapping from 31 to 0.
REQ-026 SHALL, when req=1 and idle=1, drive cnt_data with counter[idx] and cnt_valid=1 on the next cycle; otherwise cnt_valid=0 and cnt_data=0.
REQ-027 SHALL return the pre-increment counter value when a read and an increment coincide.
REQ-028 SHALL keep pop at 0 for blocked sources and SHALL NOT reorder words from the same source.

Reset
REQ-029 SHALL, while reset=1, force pop=0, push=0, data_out=0, idle=0, cnt_valid=0 and cnt_data=0, with all counters at 0, the round-robin pointer at 0 and the FSM in INIT.
REQ-030 SHALL discard any in-flight word on reset mid-operation, and push SHALL drop immediately (asynchronously).

Structure
REQ-031 SHALL place DATA_W, N_VC, the destination-field bit positions and the FSM state encodings in a shared package.
REQ-032 SHALL implement the round-robin priority encoder as the sub-module rr_grant (inputs: eligible vector and pointer; output: one-hot grant).

Verification
REQ-033 SHALL cover: reset, then a single word 10'h1A5 in FIFO0 (dest 1) -> pop[0] in cycle t, push=4'b0010 and data_out=10'h1A5 in cycle t+1, counter[1]=1.
REQ-034 SHALL cover: all four FIFOs non-empty, each head to dest 0 -> pops granted in order 0,1,2,3,0, one per cycle, and 5 consecutive pushes.
REQ-035 SHALL cover: alm_full[2]=1 with FIFO1 head to dest 2 and FIFO3 head to dest 0 -> only FIFO3 is popped; FIFO1 is popped the cycle after alm_full[2] falls.
REQ-036 SHALL cover: alm_full rising in the cycle after a pop -> the in-flight word is still pushed and no further pop to that destination occurs.
REQ-037 SHALL cover: 33 pushes to dest 3, then req=1, idx=3 in idle -> cnt_data=1 and cnt_valid=1 one cycle later.
REQ-038 SHALL cover: reset asserted in the cycle between pop and push -> no push, all outputs 0, and after release the grant starts again at source 0.
